// File: rtl/commit_stage.sv
// Commit stage: retires the instruction from execute and drives GPR/CSR writeback.
// It also arbitrates traps and xRET, waits for load data with a timeout, and flushes younger stages.
package mode;
    typedef enum logic [1:0] {
        MODE_U = 2'd0,
        MODE_S = 2'd1,
        MODE_M = 2'd3
    } mode_t;
endpackage

module commit_stage #(
    parameter int LOAD_TIMEOUT = 255,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         valid5,
    input  logic         we5,
    input  logic [4:0]   rd5,
    input  logic [31:0]  result5,
    input  logic         load5,
    input  logic         csr_we5,
    input  logic [11:0]  csr_addr5,
    input  logic [31:0]  csr_wdata5,
    input  logic [31:0]  pc5,
    input  logic         instruction_addr_misaligned5,
    input  logic         illegal_instr5,
    input  logic         ecall5,
    input  logic         mret5,
    input  logic         sret5,
    input  logic         uret5,
    input  logic         m_interrupt,
    input  logic         s_interrupt,
    input  mode::mode_t  current_mode,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata,
    output logic         we6,
    output logic [4:0]   rdaddr6,
    output logic [31:0]  wb6,
    output logic [31:0]  csr_wb,
    output logic [11:0]  csr_wb_addr,
    output logic [31:0]  m_cause,
    output logic         exception_pending,
    output logic [31:0]  pc_exc,
    output logic         m_ret,
    output logic         s_ret,
    output logic         u_ret,
    output logic         flush,
    output logic         stall_commit
);

    localparam int LCW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [LCW-1:0] LOAD_LAST  = LCW'(LOAD_TIMEOUT - 1);
    localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_FLUSH     = 2'd2
    } state_t;

    state_t          state_r;
    logic [LCW-1:0]  load_cnt_r;
    logic [FCW-1:0]  flush_cnt_r;
    logic [4:0]      ld_rd_r;
    logic [31:0]     ld_pc_r;

    logic            accept_s;
    logic            trap_s;
    logic            xret_s;
    logic [31:0]     cause_s;

    assign accept_s = valid5 & (state_r == ST_RUN) & ~flush;
    assign xret_s   = mret5 | sret5 | uret5;

    // Trap arbitration for the instruction in execute; illegal xRETs fold into cause 2.
    always_comb begin
        trap_s  = 1'b1;
        cause_s = 32'd0;
        if (m_interrupt) begin
            cause_s = 32'h8000_000B;
        end else if (s_interrupt) begin
            cause_s = 32'h8000_0009;
        end else if (instruction_addr_misaligned5) begin
            cause_s = 32'd0;
        end else if (illegal_instr5 || (mret5 && current_mode != mode::MODE_M) ||
                     (sret5 && current_mode == mode::MODE_U)) begin
            cause_s = 32'd2;
        end else if (ecall5) begin
            case (current_mode)
                mode::MODE_U: cause_s = 32'd8;
                mode::MODE_S: cause_s = 32'd9;
                mode::MODE_M: cause_s = 32'd11;
                default:      cause_s = 32'd11;
            endcase
        end else begin
            trap_s  = 1'b0;
            cause_s = 32'd0;
        end
    end

    // Commit FSM; writeback, trap and xRET strobes are one-cycle registered pulses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r           <= ST_RUN;
            load_cnt_r        <= '0;
            flush_cnt_r       <= '0;
            ld_rd_r           <= 5'd0;
            ld_pc_r           <= 32'd0;
            we6               <= 1'b0;
            rdaddr6           <= 5'd0;
            wb6               <= 32'd0;
            csr_wb            <= 32'd0;
            csr_wb_addr       <= 12'h000;
            m_cause           <= 32'd0;
            exception_pending <= 1'b0;
            pc_exc            <= 32'd0;
            m_ret             <= 1'b0;
            s_ret             <= 1'b0;
            u_ret             <= 1'b0;
            flush             <= 1'b0;
            stall_commit      <= 1'b0;
        end else begin
            we6               <= 1'b0;
            csr_wb_addr       <= 12'h000;
            exception_pending <= 1'b0;
            m_ret             <= 1'b0;
            s_ret             <= 1'b0;
            u_ret             <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (accept_s) begin
                        if (trap_s) begin
                            exception_pending <= 1'b1;
                            m_cause           <= cause_s;
                            pc_exc            <= pc5;
                            flush             <= 1'b1;
                            flush_cnt_r       <= FLUSH_INIT;
                            state_r           <= ST_FLUSH;
                        end else if (xret_s) begin
                            m_ret       <= mret5;
                            s_ret       <= sret5;
                            u_ret       <= uret5;
                            flush       <= 1'b1;
                            flush_cnt_r <= FLUSH_INIT;
                            state_r     <= ST_FLUSH;
                        end else if (load5) begin
                            ld_rd_r      <= rd5;
                            ld_pc_r      <= pc5;
                            load_cnt_r   <= '0;
                            stall_commit <= 1'b1;
                            state_r      <= ST_WAIT_LOAD;
                        end else begin
                            we6     <= we5 & (rd5 != 5'd0);
                            rdaddr6 <= rd5;
                            wb6     <= result5;
                            if (csr_we5) begin
                                csr_wb_addr <= csr_addr5;
                                csr_wb      <= csr_wdata5;
                            end
                        end
                    end
                end
                ST_WAIT_LOAD: begin
                    // Data arriving on the timeout cycle still completes the load.
                    if (mem_rvalid) begin
                        we6          <= (ld_rd_r != 5'd0);
                        rdaddr6      <= ld_rd_r;
                        wb6          <= mem_rdata;
                        load_cnt_r   <= '0;
                        stall_commit <= 1'b0;
                        state_r      <= ST_RUN;
                    end else if (load_cnt_r == LOAD_LAST) begin
                        exception_pending <= 1'b1;
                        m_cause           <= 32'd5;
                        pc_exc            <= ld_pc_r;
                        flush             <= 1'b1;
                        flush_cnt_r       <= FLUSH_INIT;
                        load_cnt_r        <= '0;
                        stall_commit      <= 1'b0;
                        state_r           <= ST_FLUSH;
                    end else begin
                        load_cnt_r <= load_cnt_r + LCW'(1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r == '0) begin
                        flush   <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - FCW'(1);
                    end
                end
                default: begin
                    flush        <= 1'b0;
                    stall_commit <= 1'b0;
                    state_r      <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/commit_stage.md
Name: commit_stage

Overview:
- Final pipeline stage.
- Takes the resolved instruction from execute, retires it, and drives the writeback interface consumed by issue: GPR write, CSR write, trap entry and xRET.
- Arbitrates exceptions and interrupts, waits on outstanding load data with a timeout, and flushes younger stages for a fixed window after a trap.

Parameters:
- LOAD_TIMEOUT, 255: maximum cycles waiting for mem_rvalid before raising a load access fault.
- FLUSH_CYCLES, 2: cycles flush stays asserted after a trap or xRET; must be ≥ 1.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- valid5  in  1  execute presents an instruction this cycle
- we5  in  1  instruction writes a GPR
- rd5  in  5  destination GPR
- result5  in  32  ALU/CSR-read result
- load5  in  1  instruction is a load; data arrives on mem_rdata
- csr_we5  in  1  CSR write request
- csr_addr5  in  12  CSR address
- csr_wdata5  in  32  CSR write data
- pc5  in  32  instruction PC
- instruction_addr_misaligned5, illegal_instr5, ecall5  in  1 each  synchronous exception flags
- mret5, sret5, uret5  in  1 each  xRET flags
- m_interrupt, s_interrupt  in  1 each  pending enabled interrupts
- current_mode  in  mode::mode_t  privilege mode: U=0, S=1, M=3
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data
- we6  out  1  GPR write enable
- rdaddr6  out  5  GPR write address
- wb6  out  32  GPR write data
- csr_wb  out  32  CSR write data
- csr_wb_addr  out  12  CSR write address; 12'h000 means no write
- m_cause  out  32  trap cause
- exception_pending  out  1  trap-entry pulse
- pc_exc  out  32  faulting PC
- m_ret, s_ret, u_ret  out  1 each  xRET pulses
- flush  out  1  kill younger stages
- stall_commit  out  1  hold execute

Behaviour:
- Clock and reset: one clock clk. nrst is asynchronous, active-low. On reset every output is 0, state = RUN, timeout counter = 0.
- All outputs are registered. An instruction accepted in cycle N produces its writeback, trap or xRET in cycle N+1.
- An instruction is accepted when valid5=1, state=RUN and flush=0.
- FSM states: RUN, WAIT_LOAD, FLUSH.
- Trap priority on an accepted instruction, highest first:
  1. m_interrupt: cause 32'h8000000B.
  2. s_interrupt: cause 32'h80000009.
  3. instruction_addr_misaligned5: cause 0.
  4. illegal_instr5, or mret5 with current_mode≠M, or sret5 with current_mode=U: cause 2.
  5. ecall5: cause 8 in U, 9 in S, 11 in M.
- On a trap, next cycle:
  - exception_pending=1, m_cause=cause, pc_exc=pc5, flush=1.
  - we6=0 and csr_wb_addr=0; GPR and CSR writes are suppressed.
  - State goes to FLUSH.
- Legal xRET, next cycle: the matching *_ret pulses for 1 cycle, flush=1, state goes to FLUSH. At most one xRET flag is set per instruction.
- Normal non-load instruction:
  - we6 = we5 & (rd5≠0); rdaddr6=rd5; wb6=result5.
  - If csr_we5: csr_wb_addr=csr_addr5, csr_wb=csr_wdata5; otherwise csr_wb_addr=0.
  - we6 and the CSR write are single-cycle pulses.
- Load with no trap:
  - rd5 is latched and state goes to WAIT_LOAD. stall_commit=1 from the next cycle until the cycle after mem_rvalid.
  - In WAIT_LOAD the counter increments each cycle without mem_rvalid.
  - On mem_rvalid: we6=(rd≠0), wb6=mem_rdata, rdaddr6=latched rd, counter cleared, state goes to RUN.
  - If mem_rvalid and the timeout coincide, mem_rvalid wins.
  - Timeout: when the counter reaches LOAD_TIMEOUT-1 without mem_rvalid, signal a trap with cause 5 and pc_exc = latched PC; state goes to FLUSH.
- FLUSH:
  - flush=1 for FLUSH_CYCLES cycles total, counting the entry cycle.
  - valid5 is ignored in FLUSH; those instructions are killed with no writeback.
  - After the window, state returns to RUN.
- Interrupts are sampled only on accepted instructions, never in WAIT_LOAD or FLUSH.
- exception_pending and *_ret are mutually exclusive single-cycle pulses.
- Reset mid-operation: asserting nrst in any state clears outputs and counters immediately, with no pending writeback.

Test Plan:
- ADD: valid5=1, we5=1, rd5=5, result5=32'h1234 → next cycle we6=1, rdaddr6=5, wb6=32'h1234. A write to rd5=0 gives we6=0.
- Load: load5=1, rd5=7; mem_rvalid arrives 3 cycles later with 32'hDEADBEEF → stall_commit high for 3 cycles, then we6=1, rdaddr6=7, wb6=32'hDEADBEEF, stall_commit=0.
- Timeout: load with LOAD_TIMEOUT=4 and no rvalid → exception_pending=1, m_cause=5, pc_exc=load PC, flush high for 2 cycles, we6 stays 0.
- Priority: ecall5=1, illegal_instr5=1, m_interrupt=1 at pc5=32'h100 → m_cause=32'h8000000B, pc_exc=32'h100, csr_wb_addr=0. Repeating with no interrupt in U mode → m_cause=2.
- xRET: mret5 in M → m_ret pulse, flush for 2 cycles, and valid5 during flush is killed with no we6. mret5 in S → m_cause=2, m_ret=0.
- Reset: nrst low during WAIT_LOAD → all outputs 0 asynchronously. After release, a normal ADD retires with 1-cycle latency.
